pipe_mips_param: RTL

PIPE_MIPS_PARAM -- requirements
Module: pipe_mips_param

---
 rtl/pipe_mips_param.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_mips_param.sv
// Five-stage IF/ID/EX/MEM/WB MIPS-like core: EX operand forwarding (or pure
// interlocking when FWD_EN=0), EX-resolved branches and a sticky halt.
module pipe_mips_param #(
    parameter int DW     = 32,
    parameter int IAW    = 10,
    parameter int DAW    = 10,
    parameter int FWD_EN = 1
) (
    input  logic           clk,
    input  logic           rst,
    output logic [IAW-1:0] imem_addr,
    input  logic [31:0]    imem_rdata,
    output logic [DAW-1:0] dmem_addr,
    output logic [DW-1:0]  dmem_wdata,
    output logic           dmem_we,
    input  logic [DW-1:0]  dmem_rdata,
    input  logic [4:0]     dbg_raddr,
    output logic [DW-1:0]  dbg_rdata,
    output logic           halted,
    output logic [31:0]    retire_cnt
);
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    function automatic logic [DW-1:0] alu(input logic [5:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic signed [DW-1:0] imm);
        logic [DW-1:0] r;
        r = '0;
        case (op)
            OP_ADD:               r = a + b;
            OP_SUB:               r = a - b;
            OP_AND:               r = a & b;
            OP_OR:                r = a | b;
            OP_SLT:               r = (a < b) ? DW'(1) : '0;
            OP_MUL:               r = a * b;
            OP_ADDI, OP_LW, OP_SW: r = a + $unsigned(imm);
            OP_SUBI:              r = a - $unsigned(imm);
            OP_SLTI:              r = (a < $unsigned(imm)) ? DW'(1) : '0;
            default:              r = '0;
        endcase
        return r;
    endfunction

    logic [IAW-1:0] pc_q, pc_d;
    logic           stop_q, stop_d, halted_q, halted_d;
    logic [31:0]    retire_q, retire_d;
    logic           vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d, vld_p4_q, vld_p4_d;
    logic [31:0]    ir_p1_q, ir_p1_d;
    logic [IAW-1:0] pc_p1_q, pc_p1_d, pc_p2_q, pc_p2_d;
    logic [5:0]     op_p2_q, op_p2_d, op_p3_q, op_p3_d;
    logic [4:0]     rs_p2_q, rs_p2_d, rt_p2_q, rt_p2_d;
    logic [4:0]     dst_p2_q, dst_p2_d, dst_p3_q, dst_p3_d, dst_p4_q, dst_p4_d;
    logic           wen_p2_q, wen_p2_d, wen_p3_q, wen_p3_d, wen_p4_q, wen_p4_d;
    logic [DW-1:0]  a_p2_q, a_p2_d, b_p2_q, b_p2_d;
    logic signed [DW-1:0] imm_p2_q, imm_p2_d;
    logic [DW-1:0]  res_p3_q, res_p3_d, sd_p3_q, sd_p3_d, res_p4_q, res_p4_d;
    logic           hlt_p4_q, hlt_p4_d;
    logic [DW-1:0]  rf_q [32];

    logic [5:0]     id_op;
    logic [4:0]     id_rs, id_rt, id_dst;
    logic signed [15:0] id_imm16;
    logic           id_r, id_i, id_lw, id_sw, id_br, id_hlt, id_use_rt, id_wen;
    logic [DW-1:0]  id_a, id_b, ex_a, ex_b, ex_res, mem_res;
    logic           rf_we, hit_p2, hit_p3, stall, flush, hlt_in_id;
    logic [IAW-1:0] br_tgt;

    assign rf_we = vld_p4_q && wen_p4_q && !halted_q;

    // ID: decode, register read with same-cycle WB bypass, hazard detection
    always_comb begin
        id_op     = ir_p1_q[31:26];
        id_rs     = ir_p1_q[25:21];
        id_rt     = ir_p1_q[20:16];
        id_imm16  = ir_p1_q[15:0];
        id_r      = (id_op <= OP_MUL);
        id_i      = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
        id_lw     = (id_op == OP_LW);
        id_sw     = (id_op == OP_SW);
        id_br     = (id_op == OP_BNEQZ) || (id_op == OP_BEQZ);
        id_hlt    = !(id_r || id_i || id_lw || id_sw || id_br);
        id_use_rt = id_r || id_sw;
        id_dst    = id_r ? ir_p1_q[15:11] : id_rt;
        // R0 destinations are dropped here so they can never write or forward
        id_wen    = (id_r || id_i || id_lw) && (id_dst != 5'd0);
        id_a      = (rf_we && dst_p4_q == id_rs) ? res_p4_q : rf_q[id_rs];
        id_b      = (rf_we && dst_p4_q == id_rt) ? res_p4_q : rf_q[id_rt];
        hit_p2    = vld_p2_q && wen_p2_q &&
                    ((!id_hlt && id_rs == dst_p2_q) || (id_use_rt && id_rt == dst_p2_q));
        hit_p3    = vld_p3_q && wen_p3_q &&
                    ((!id_hlt && id_rs == dst_p3_q) || (id_use_rt && id_rt == dst_p3_q));
        stall     = vld_p1_q && !flush &&
                    ((hit_p2 && op_p2_q == OP_LW) || ((FWD_EN == 0) && (hit_p2 || hit_p3)));
        hlt_in_id = vld_p1_q && id_hlt && !flush;
    end

    // EX: operand forwarding, ALU, branch resolution
    always_comb begin
        ex_a = a_p2_q;
        ex_b = b_p2_q;
        if (FWD_EN != 0) begin
            if (vld_p3_q && wen_p3_q && dst_p3_q == rs_p2_q)      ex_a = res_p3_q;
            else if (vld_p4_q && wen_p4_q && dst_p4_q == rs_p2_q) ex_a = res_p4_q;
            if (vld_p3_q && wen_p3_q && dst_p3_q == rt_p2_q)      ex_b = res_p3_q;
            else if (vld_p4_q && wen_p4_q && dst_p4_q == rt_p2_q) ex_b = res_p4_q;
        end
        ex_res = alu(op_p2_q, ex_a, ex_b, imm_p2_q);
        flush  = vld_p2_q && ((op_p2_q == OP_BEQZ && ex_a == '0) ||
                              (op_p2_q == OP_BNEQZ && ex_a != '0));
        br_tgt = pc_p2_q + IAW'(1) + IAW'(imm_p2_q);
    end

    // MEM: load data replaces the address on its way to WB
    assign mem_res = (op_p3_q == OP_LW) ? dmem_rdata : res_p3_q;

    always_comb begin
        pc_d = pc_q;          stop_d = stop_q;      halted_d = halted_q;  retire_d = retire_q;
        vld_p1_d = vld_p1_q;  ir_p1_d = ir_p1_q;    pc_p1_d = pc_p1_q;
        vld_p2_d = vld_p2_q;  op_p2_d = op_p2_q;    rs_p2_d = rs_p2_q;    rt_p2_d = rt_p2_q;
        dst_p2_d = dst_p2_q;  wen_p2_d = wen_p2_q;  a_p2_d = a_p2_q;      b_p2_d = b_p2_q;
        imm_p2_d = imm_p2_q;  pc_p2_d = pc_p2_q;
        vld_p3_d = vld_p3_q;  op_p3_d = op_p3_q;    dst_p3_d = dst_p3_q;  wen_p3_d = wen_p3_q;
        res_p3_d = res_p3_q;  sd_p3_d = sd_p3_q;
        vld_p4_d = vld_p4_q;  dst_p4_d = dst_p4_q;  wen_p4_d = wen_p4_q;  res_p4_d = res_p4_q;
        hlt_p4_d = hlt_p4_q;
        // Once halted every register holds until reset
        if (!halted_q) begin
            if (flush) begin
                pc_d     = br_tgt;
                vld_p1_d = 1'b0;
            end else if (stall) begin
                vld_p1_d = vld_p1_q;
            end else if (hlt_in_id || stop_q) begin
                vld_p1_d = 1'b0;
            end else begin
                pc_d     = pc_q + IAW'(1);
                vld_p1_d = 1'b1;
                ir_p1_d  = imem_rdata;
                pc_p1_d  = pc_q;
            end
            stop_d   = stop_q || hlt_in_id;
            vld_p2_d = vld_p1_q && !flush && !stall;
            op_p2_d  = id_hlt ? OP_HLT : id_op;
            rs_p2_d  = id_rs;
            rt_p2_d  = id_rt;
            dst_p2_d = id_dst;
            wen_p2_d = id_wen;
            a_p2_d   = id_a;
            b_p2_d   = id_b;
            imm_p2_d = DW'(id_imm16);
            pc_p2_d  = pc_p1_q;
            vld_p3_d = vld_p2_q;
            op_p3_d  = op_p2_q;
            dst_p3_d = dst_p2_q;
            wen_p3_d = wen_p2_q;
            res_p3_d = ex_res;
            sd_p3_d  = ex_b;
            vld_p4_d = vld_p3_q;
            dst_p4_d = dst_p3_q;
            wen_p4_d = wen_p3_q;
            res_p4_d = mem_res;
            hlt_p4_d = (op_p3_q == OP_HLT);
            halted_d = vld_p4_q && hlt_p4_q;
            retire_d = retire_q + {31'd0, vld_p4_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            stop_q   <= 1'b0;
            halted_q <= 1'b0;
            retire_q <= '0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            vld_p4_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            stop_q   <= stop_d;
            halted_q <= halted_d;
            retire_q <= retire_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            vld_p4_q <= vld_p4_d;
        end
    end

    always_ff @(posedge clk) begin
        ir_p1_q  <= ir_p1_d;   pc_p1_q  <= pc_p1_d;
        op_p2_q  <= op_p2_d;   rs_p2_q  <= rs_p2_d;   rt_p2_q  <= rt_p2_d;   dst_p2_q <= dst_p2_d;
        wen_p2_q <= wen_p2_d;  a_p2_q   <= a_p2_d;    b_p2_q   <= b_p2_d;    imm_p2_q <= imm_p2_d;
        pc_p2_q  <= pc_p2_d;
        op_p3_q  <= op_p3_d;   dst_p3_q <= dst_p3_d;  wen_p3_q <= wen_p3_d;  res_p3_q <= res_p3_d;
        sd_p3_q  <= sd_p3_d;
        dst_p4_q <= dst_p4_d;  wen_p4_q <= wen_p4_d;  res_p4_q <= res_p4_d;  hlt_p4_q <= hlt_p4_d;
    end

    // WB: register file write; R0 is never written so it always reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[dst_p4_q] <= res_p4_q;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = res_p3_q[DAW-1:0];
    assign dmem_wdata = sd_p3_q;
    assign dmem_we    = vld_p3_q && (op_p3_q == OP_SW) && !halted_q;
    assign dbg_rdata  = rf_q[dbg_raddr];
    assign halted     = halted_q;
    assign retire_cnt = retire_q;
endmodule
